// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Tiny program sequencer for a 4-word, 2-bit program memory.
//            Executes INC (00), JNO (01, with a jump-target operand word),
//            HLT (10). Opcode 11 is illegal and halts with err set.
// Ports    : clk        - clock, all state updates on rising edge
//            rst_n      - asynchronous active-low reset
//            start      - run request, honoured only in IDLE or HALT
//            instr[1:0] - program memory word at address {sel1,sel2}
//            sel1/sel2  - program address MSB/LSB (pc[1], pc[0])
//            acc        - accumulator, ACC_WIDTH bits
//            ovf        - overflow flag from the last INC
//            busy       - high in FETCH, EXEC and OPERAND
//            halted     - high in HALT
//            err        - illegal opcode seen, valid while halted
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int ACC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           instr,
  output logic                 sel1,
  output logic                 sel2,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 busy,
  output logic                 halted,
  output logic                 err
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_FETCH   = 3'd1;
  localparam logic [2:0] c_EXEC    = 3'd2;
  localparam logic [2:0] c_OPERAND = 3'd3;
  localparam logic [2:0] c_HALT    = 3'd4;

  localparam logic [1:0] c_OP_INC  = 2'b00;
  localparam logic [1:0] c_OP_JNO  = 2'b01;
  localparam logic [1:0] c_OP_HLT  = 2'b10;

  logic [2:0]           r_state;
  logic [1:0]           r_pc;
  logic [1:0]           r_ir;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_halted;

  logic [2:0]           w_state_nxt;
  logic [1:0]           w_pc_nxt;
  logic [1:0]           w_ir_nxt;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic                 w_ovf_nxt;
  logic                 w_err_nxt;
  logic [1:0]           w_pc_inc;

  // 2-bit add wraps 3 -> 0 naturally
  assign w_pc_inc = r_pc + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_err_nxt   = r_err;
    case (r_state)
      c_IDLE: begin
        if (start) w_state_nxt = c_FETCH;
      end
      c_FETCH: begin
        w_ir_nxt    = instr;
        w_state_nxt = c_EXEC;
      end
      c_EXEC: begin
        case (r_ir)
          c_OP_INC: begin
            w_acc_nxt   = r_acc + 1'b1;
            w_ovf_nxt   = &r_acc;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = c_FETCH;
          end
          c_OP_JNO: begin
            // Step onto the operand word; the jump decision happens next cycle
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = c_OPERAND;
          end
          c_OP_HLT: begin
            w_state_nxt = c_HALT;
          end
          default: begin
            w_err_nxt   = 1'b1;
            w_state_nxt = c_HALT;
          end
        endcase
      end
      c_OPERAND: begin
        // Memory word at pc is the jump target; skip over it on overflow
        w_pc_nxt    = r_ovf ? w_pc_inc : instr;
        w_state_nxt = c_FETCH;
      end
      c_HALT: begin
        if (start) begin
          w_pc_nxt    = 2'd0;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = c_FETCH;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // busy/halted are registered from the next-state value so that every
  // output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_pc     <= 2'd0;
      r_ir     <= 2'd0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_acc    <= w_acc_nxt;
      r_ovf    <= w_ovf_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt == c_FETCH) || (w_state_nxt == c_EXEC) ||
                  (w_state_nxt == c_OPERAND);
      r_halted <= (w_state_nxt == c_HALT);
    end
  end

  assign sel1   = r_pc[1];
  assign sel2   = r_pc[0];
  assign acc    = r_acc;
  assign ovf    = r_ovf;
  assign busy   = r_busy;
  assign halted = r_halted;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer. Expected halt results
//            are queued by the stimulus; a monitor pops one on every rising
//            edge of halted and compares it with the observed run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] instr;
  logic       sel1, sel2;
  logic [3:0] acc;
  logic       ovf, busy, halted, err;

  logic [1:0] prog [4];

  instr_sequencer #(.ACC_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .instr  (instr),
    .sel1   (sel1),
    .sel2   (sel2),
    .acc    (acc),
    .ovf    (ovf),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign instr = prog[{sel1, sel2}];

  typedef struct {
    int         edges;
    logic [3:0] acc;
    logic       ovf;
    logic       err;
    logic [1:0] sel;
    int         taken;
    int         nt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Edge at which start is sampled in IDLE/HALT (pre-edge values)
  int start_gen = 0;
  always @(posedge clk) begin
    if (rst_n && start && !busy) start_gen++;
  end

  // Monitor: edge count since start, address-trace jump counts, halt check
  int         seen_gen = 0;
  int         edges = 0;
  int         taken = 0;
  int         nt = 0;
  logic       prev_halted = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  logic [1:0] cur_sel;
  exp_t       mexp;

  always @(negedge clk) begin
    cur_sel = {sel1, sel2};
    if (seen_gen != start_gen) begin
      seen_gen = start_gen;
      edges = 0;
      taken = 0;
      nt = 0;
    end else begin
      edges++;
    end
    if (prev_sel == 2'd2 && cur_sel == 2'd0) taken++;
    if (prev_sel == 2'd2 && cur_sel == 2'd3) nt++;
    if (halted && !prev_halted) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_halt actual=halted expected=running");
      end else begin
        mexp = q.pop_front();
        chk("halt_edges", edges, mexp.edges);
        chk("halt_acc",   acc,   mexp.acc);
        chk("halt_ovf",   ovf,   mexp.ovf);
        chk("halt_err",   err,   mexp.err);
        chk("halt_sel",   cur_sel, mexp.sel);
        chk("jno_taken",  taken, mexp.taken);
        chk("jno_nottaken", nt,  mexp.nt);
      end
    end
    prev_halted = halted;
    prev_sel    = cur_sel;
  end

  task automatic wait_halt(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout actual=busy expected=halted within %0d", max_cycles);
    end
    @(negedge clk);
  endtask

  // Pulse start across exactly one rising edge; returns just after it
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  exp_t exp_loop;
  exp_t exp_ill;

  initial begin
    exp_loop = '{edges: 82, acc: 4'd0, ovf: 1'b1, err: 1'b0, sel: 2'd3, taken: 15, nt: 1};
    exp_ill  = '{edges: 2,  acc: 4'd0, ovf: 1'b0, err: 1'b1, sel: 2'd0, taken: 0,  nt: 0};
    prog  = '{2'b00, 2'b01, 2'b00, 2'b10};
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    // Reset held with clocks and start active: nothing moves
    chk("rst_sel",    {sel1, sel2}, 2'd0);
    chk("rst_acc",    acc,    4'd0);
    chk("rst_flags",  {ovf, err}, 2'b00);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_halted", halted, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_wait", busy, 1'b0);

    // Counting loop from IDLE
    q.push_back(exp_loop);
    pulse_start();
    chk("run_busy", busy, 1'b1);
    wait_halt(200);
    repeat (2) @(negedge clk);
    chk("halt_hold", {halted, acc, ovf}, {1'b1, 4'd0, 1'b1});

    // Restart from HALT with start held high through part of the run
    q.push_back(exp_loop);
    start = 1'b1;
    @(negedge clk);
    chk("restart_state", {busy, halted, sel1, sel2}, 4'b1000);
    chk("restart_clear", {acc, ovf, err}, 6'd0);
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_halt(200);

    // Illegal opcode at address 0
    prog = '{2'b11, 2'b10, 2'b10, 2'b10};
    q.push_back(exp_ill);
    pulse_start();
    wait_halt(20);

    // Asynchronous reset while in OPERAND
    prog = '{2'b00, 2'b01, 2'b00, 2'b10};
    pulse_start();
    repeat (4) @(negedge clk);
    chk("operand_pos", {busy, sel1, sel2, acc}, {1'b1, 2'd2, 4'd1});
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("async_sel",   {sel1, sel2}, 2'd0);
    chk("async_acc",   acc, 4'd0);
    chk("async_flags", {ovf, err, busy, halted}, 4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_ignore_start", {busy, sel1, sel2, acc}, 7'd0);
    q.push_back(exp_loop);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_start", busy, 1'b1);
    wait_halt(200);

    // Straight-line INC program: pc wraps, acc counts every 2 edges
    prog = '{2'b00, 2'b00, 2'b00, 2'b00};
    pulse_start();
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      if (e == 8)  chk("inc_wrap",  {sel1, sel2, acc, ovf}, {2'd0, 4'd4, 1'b0});
      if (e == 30) chk("inc_15",    {sel1, sel2, acc, ovf}, {2'd3, 4'd15, 1'b0});
      if (e == 32) chk("inc_ovf",   {sel1, sel2, acc, ovf}, {2'd0, 4'd0, 1'b1});
      if (e == 33) chk("inc_hold",  {acc, ovf}, {4'd0, 1'b1});
      if (e == 34) chk("inc_clr",   {sel1, sel2, acc, ovf}, {2'd1, 4'd1, 1'b0});
    end

    rst_n = 1'b0;
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
